// File: rtl/schwap_pkg.sv
// Shared definitions for the windowed register file.
//   clr_state_t : clear-engine FSM encoding (IDLE=0, CLEAR=1)
//   DEF_*       : default width parameters
package schwap_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_WIN_W  = 4;

endpackage

// File: rtl/schwap_win_ctrl.sv
// Window controller: current window, push/pop depth tracking, rejection
// pulses and the multi-cycle window-clear engine. Produces the effective
// write port (user write or clear write) for the storage array.
//
// state | meaning
// IDLE  | normal operation, user writes and window ops accepted
// CLEAR | zeroing reg[cur_win][cnt], one register per cycle
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   write_en/write_addr/write_data    user write request
//   win_load/win_sel                  absolute window load
//   win_push/win_pop                  relative window moves
//   win_clear                         start clearing the current window
//   cur_win, depth                    current window and push depth
//   busy, overflow, underflow         clear active, push/pop rejected pulses
//   arr_we/arr_addr/arr_data          effective write into the array
//   wr_accept                         user write accepted this cycle
module schwap_win_ctrl
  import schwap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WIN_W  = DEF_WIN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              win_load,
  input  logic [WIN_W-1:0]  win_sel,
  input  logic              win_push,
  input  logic              win_pop,
  input  logic              win_clear,
  output logic [WIN_W-1:0]  cur_win,
  output logic [WIN_W-1:0]  depth,
  output logic              busy,
  output logic              overflow,
  output logic              underflow,
  output logic              arr_we,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [DATA_W-1:0] arr_data,
  output logic              wr_accept
);

  localparam logic [WIN_W-1:0]  MAX_DEPTH = '1;
  localparam logic [ADDR_W-1:0] LAST_REG  = '1;

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic              win_op;

  // Any window strobe (even a cancelling push+pop) suppresses a clear request.
  assign win_op = win_load | win_push | win_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_win   <= '0;
      depth     <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      case (state)
        IDLE: begin
          if (win_load) begin
            cur_win <= win_sel;
          end else if (win_push && !win_pop) begin
            if (depth == MAX_DEPTH) begin
              overflow <= 1'b1;
            end else begin
              cur_win <= cur_win + 1'b1;
              depth   <= depth + 1'b1;
            end
          end else if (win_pop && !win_push) begin
            if (depth == '0) begin
              underflow <= 1'b1;
            end else begin
              cur_win <= cur_win - 1'b1;
              depth   <= depth - 1'b1;
            end
          end else if (win_clear && !win_op) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_REG) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_accept = write_en && !busy;
  // Array writes are held off during reset so a reset mid-clear freezes the
  // array exactly as the clear had left it.
  assign arr_we    = (busy || write_en) && !reset;
  assign arr_addr  = busy ? cnt : write_addr;
  assign arr_data  = busy ? '0 : write_data;

endmodule

// File: rtl/schwap_window_file.sv
// Windowed architectural register file: 2^WIN_W windows of 2^ADDR_W
// registers, DATA_W bits each, with registered dual read ports and
// write-to-read bypass.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   write/writeAddr/writeData       write into the current window
//   readAddrA/B -> readDataA/B      registered reads of the current window
//   winLoad/winSel/winPush/winPop   window selection
//   winClear                        zero every register of the current window
//   curWin, depth                   current window and push depth
//   busy, overflow, underflow       clear active, push/pop rejected pulses
module schwap_window_file
  import schwap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WIN_W  = DEF_WIN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddrA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  input  logic              winLoad,
  input  logic [WIN_W-1:0]  winSel,
  input  logic              winPush,
  input  logic              winPop,
  input  logic              winClear,
  output logic [WIN_W-1:0]  curWin,
  output logic [WIN_W-1:0]  depth,
  output logic              busy,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << (WIN_W + ADDR_W);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_data;
  logic              wr_accept;

  schwap_win_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .WIN_W (WIN_W)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write),
    .write_addr(writeAddr),
    .write_data(writeData),
    .win_load  (winLoad),
    .win_sel   (winSel),
    .win_push  (winPush),
    .win_pop   (winPop),
    .win_clear (winClear),
    .cur_win   (curWin),
    .depth     (depth),
    .busy      (busy),
    .overflow  (overflow),
    .underflow (underflow),
    .arr_we    (arr_we),
    .arr_addr  (arr_addr),
    .arr_data  (arr_data),
    .wr_accept (wr_accept)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem[{curWin, arr_addr}] <= arr_data;
    end
  end

  // Bypass only covers accepted user writes; clear writes are not forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      readDataA <= '0;
      readDataB <= '0;
    end else begin
      readDataA <= (wr_accept && (writeAddr == readAddrA)) ? writeData
                                                            : mem[{curWin, readAddrA}];
      readDataB <= (wr_accept && (writeAddr == readAddrB)) ? writeData
                                                            : mem[{curWin, readAddrB}];
    end
  end

endmodule

// File: tb/tb_schwap_window_file.sv
module tb_schwap_window_file;

  localparam int S_RDA = 0, S_RDB = 1, S_WIN = 2, S_DEP = 3,
                 S_BSY = 4, S_OVF = 5, S_UNF = 6;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] exp;
    string       name;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic [1:0]  writeAddr = '0;
  logic [15:0] writeData = '0;
  logic [1:0]  readAddrA = '0;
  logic [1:0]  readAddrB = '0;
  logic [15:0] readDataA, readDataB;
  logic        winLoad = 1'b0;
  logic [3:0]  winSel = '0;
  logic        winPush = 1'b0;
  logic        winPop = 1'b0;
  logic        winClear = 1'b0;
  logic [3:0]  curWin, depth;
  logic        busy, overflow, underflow;

  sb_item_t sb[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  schwap_window_file dut (
    .clk(clk), .reset(reset), .write(write), .writeAddr(writeAddr),
    .writeData(writeData), .readAddrA(readAddrA), .readAddrB(readAddrB),
    .readDataA(readDataA), .readDataB(readDataB), .winLoad(winLoad),
    .winSel(winSel), .winPush(winPush), .winPop(winPop), .winClear(winClear),
    .curWin(curWin), .depth(depth), .busy(busy), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(int sig);
    case (sig)
      S_RDA:   return readDataA;
      S_RDB:   return readDataB;
      S_WIN:   return {12'd0, curWin};
      S_DEP:   return {12'd0, depth};
      S_BSY:   return {15'd0, busy};
      S_OVF:   return {15'd0, overflow};
      default: return {15'd0, underflow};
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc) begin
          failures++;
          $display("FAIL %s stale entry due cyc=%0d at cyc=%0d", sb[i].name, sb[i].cyc, cyc);
        end else if (actual(sb[i].sig) !== sb[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc,
                   actual(sb[i].sig), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  // Expect sig==val after 'dly' more rising edges.
  task automatic expect_at(int sig, logic [15:0] val, int dly, string name);
    sb_item_t it;
    it.cyc = cyc + dly;
    it.sig = sig;
    it.exp = val;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(logic [1:0] a, logic [15:0] d);
    write = 1'b1; writeAddr = a; writeData = d;
    tick();
    write = 1'b0;
  endtask

  task automatic load_win(logic [3:0] w);
    winLoad = 1'b1; winSel = w;
    tick();
    winLoad = 1'b0;
  endtask

  task automatic read_a(logic [1:0] a, logic [15:0] e, string name);
    readAddrA = a;
    expect_at(S_RDA, e, 1, name);
    tick();
  endtask

  initial begin
    int budget;
    tick(); tick();
    expect_at(S_RDA, 16'h0, 0, "rst_rda");
    expect_at(S_RDB, 16'h0, 0, "rst_rdb");
    expect_at(S_WIN, 16'h0, 0, "rst_win");
    expect_at(S_DEP, 16'h0, 0, "rst_depth");
    expect_at(S_BSY, 16'h0, 0, "rst_busy");
    expect_at(S_OVF, 16'h0, 0, "rst_ovf");
    expect_at(S_UNF, 16'h0, 0, "rst_unf");
    reset = 1'b0;
    tick();

    // write then read
    do_write(2'd2, 16'hBEEF);
    read_a(2'd2, 16'hBEEF, "rd_after_wr");

    // bypass on both ports
    write = 1'b1; writeAddr = 2'd1; writeData = 16'h1234;
    readAddrA = 2'd1; readAddrB = 2'd1;
    expect_at(S_RDA, 16'h1234, 1, "bypass_a");
    expect_at(S_RDB, 16'h1234, 1, "bypass_b");
    tick();
    write = 1'b0;

    // push/pop window isolation
    do_write(2'd0, 16'hAAAA);
    winPush = 1'b1;
    expect_at(S_WIN, 16'd1, 1, "push_win");
    expect_at(S_DEP, 16'd1, 1, "push_depth");
    tick();
    winPush = 1'b0;
    do_write(2'd0, 16'h5555);
    winPop = 1'b1;
    expect_at(S_WIN, 16'd0, 1, "pop_win");
    expect_at(S_DEP, 16'd0, 1, "pop_depth");
    tick();
    winPop = 1'b0;
    read_a(2'd0, 16'hAAAA, "win0_kept");

    // overflow
    winPush = 1'b1;
    repeat (15) tick();
    expect_at(S_DEP, 16'd15, 0, "depth15");
    expect_at(S_WIN, 16'd15, 0, "win15");
    expect_at(S_OVF, 16'd1, 1, "ovf_pulse");
    expect_at(S_DEP, 16'd15, 1, "ovf_depth");
    expect_at(S_WIN, 16'd15, 1, "ovf_win");
    tick();
    winPush = 1'b0;
    expect_at(S_OVF, 16'd0, 1, "ovf_one_cycle");
    tick();

    // underflow
    winPop = 1'b1;
    repeat (15) tick();
    expect_at(S_DEP, 16'd0, 0, "depth0");
    expect_at(S_WIN, 16'd0, 0, "win0");
    expect_at(S_UNF, 16'd1, 1, "unf_pulse");
    expect_at(S_WIN, 16'd0, 1, "unf_win");
    tick();
    winPop = 1'b0;
    expect_at(S_UNF, 16'd0, 1, "unf_one_cycle");
    tick();

    // window 1 still holds its data
    winPush = 1'b1;
    tick();
    winPush = 1'b0;
    read_a(2'd0, 16'h5555, "win1_kept");

    // push+pop together: nothing happens (depth 1 here)
    winPush = 1'b1; winPop = 1'b1;
    expect_at(S_WIN, 16'd1, 1, "pushpop_win");
    expect_at(S_DEP, 16'd1, 1, "pushpop_depth");
    expect_at(S_OVF, 16'd0, 1, "pushpop_ovf");
    expect_at(S_UNF, 16'd0, 1, "pushpop_unf");
    tick();
    winPush = 1'b0; winPop = 1'b0;

    // load keeps depth; load beats push
    winLoad = 1'b1; winSel = 4'd9;
    expect_at(S_WIN, 16'd9, 1, "load_win");
    expect_at(S_DEP, 16'd1, 1, "load_depth");
    tick();
    winSel = 4'd5; winPush = 1'b1;
    expect_at(S_WIN, 16'd5, 1, "loadpush_win");
    expect_at(S_DEP, 16'd1, 1, "loadpush_depth");
    tick();
    winLoad = 1'b0; winPush = 1'b0;

    // fill windows 2 and 3
    load_win(4'd2);
    for (int i = 0; i < 4; i++) do_write(2'(i), 16'h2000 + 16'(i));
    load_win(4'd3);
    for (int i = 0; i < 4; i++) do_write(2'(i), 16'h3000 + 16'(i));

    // clear window 3; write and push during busy are dropped
    winClear = 1'b1;
    expect_at(S_BSY, 16'd1, 1, "busy_c1");
    expect_at(S_BSY, 16'd1, 2, "busy_c2");
    expect_at(S_BSY, 16'd1, 3, "busy_c3");
    expect_at(S_BSY, 16'd1, 4, "busy_c4");
    expect_at(S_BSY, 16'd0, 5, "busy_done");
    tick();
    winClear = 1'b0;
    write = 1'b1; writeAddr = 2'd0; writeData = 16'hDEAD; winPush = 1'b1;
    expect_at(S_WIN, 16'd3, 1, "busy_push_ignored");
    tick();
    write = 1'b0; winPush = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) read_a(2'(i), 16'h0, $sformatf("cleared_r%0d", i));
    load_win(4'd2);
    for (int i = 0; i < 4; i++) read_a(2'(i), 16'h2000 + 16'(i), $sformatf("win2_r%0d", i));

    // reset in the second clear cycle
    load_win(4'd3);
    for (int i = 0; i < 4; i++) do_write(2'(i), 16'h3100 + 16'(i));
    winClear = 1'b1;
    tick();
    winClear = 1'b0;
    tick();
    reset = 1'b1;
    expect_at(S_BSY, 16'd0, 1, "rst_abort_busy");
    expect_at(S_WIN, 16'd0, 1, "rst_abort_win");
    tick();
    reset = 1'b0;
    load_win(4'd3);
    read_a(2'd0, 16'h0, "abort_r0");
    read_a(2'd2, 16'h3102, "abort_r2");
    read_a(2'd3, 16'h3103, "abort_r3");

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
